mux_arb: RTL and testbench
==========================

MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter WIDTH, default 16: bits per channel data word.
REQ-002 Parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter SELW, default 2: select and channel index width, equal to ceil(log2(CHANNELS)).
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-006 Port in_data, input, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, CHANNELS: per-channel word-available flag.
REQ-008 Port in_ready, output, CHANNELS: per-channel accept strobe; a transfer occurs when in_valid[i] and in_ready[i] are both high.
REQ-009 Port mode, input, 1: 0 = fixed select, 1 = round-robin.
REQ-010 Port sel, input, SELW: channel index used in fixed mode.
REQ-011 Port out, output, WIDTH: registered selected word.
REQ-012 Port out_valid, output, 1: out holds an untaken word.
REQ-013 Port out_ready, input, 1: downstream accepts out this cycle.
REQ-014 Port out_chan, output, SELW: source channel index of the word in out.

Function
REQ-015 The block SHALL be a one-stage registered CHANNELS:1 multiplexer with valid/ready handshake on every side.
REQ-016 The output register SHALL be "open" when out_valid is 0 or out_ready is 1.
REQ-017 At most one in_ready bit SHALL be high per cycle, and only the granted channel's bit, and only while the output register is open.
REQ-018 Fixed mode: grant SHALL go to channel sel when in_valid[sel] is 1; no grant otherwise.
REQ-019 Fixed mode: sel >= CHANNELS SHALL produce no grant.
REQ-020 Round-robin mode: grant SHALL go to the first channel with in_valid high, searching from pointer ptr upward with wrap from CHANNELS-1 to 0.
REQ-021 ptr SHALL update to (granted index + 1) mod CHANNELS only on a completed input transfer, in either mode; otherwise it holds.
REQ-022 On a transfer, the next edge SHALL load out with the granted word, out_chan with its index, and set out_valid to 1. Latency is 1 cycle from input transfer to out_valid.
REQ-023 When the register is open and no grant exists, the next edge SHALL clear out_valid to 0. out and out_chan hold their last values.
REQ-024 While out_valid is 1 and out_ready is 0, out, out_chan and out_valid SHALL be held stable and all in_ready SHALL be 0.
REQ-025 When the output is taken and a new grant occurs in the same cycle, the block SHALL sustain full throughput of one word per cycle with no bubble.
REQ-026 A change of mode or sel SHALL affect only the next arbitration. A word already in out is unaffected.
REQ-027 in_ready SHALL be combinational from in_valid, mode, sel, ptr, out_valid and out_ready. No path SHALL run from in_data to any ready signal.

Reset
REQ-028 Reset SHALL set out=0, out_valid=0, out_chan=0 and ptr=0 on the next rising edge.
REQ-029 Reset SHALL override any simultaneous transfer. A word accepted in the reset cycle is dropped, and in_ready SHALL be 0 during reset.
REQ-030 Reset asserted mid-stall SHALL discard the held word. out_valid SHALL be 0 in the following cycle regardless of out_ready.

Structure
REQ-031 A shared include header SHALL define the mode constants MODE_FIXED=0 and MODE_RR=1, for use by the RTL and the bench.
REQ-032 The round-robin search SHALL be one combinational sub-module, rr_grant. Inputs: request vector and pointer. Outputs: one-hot grant and grant index.
REQ-033 mux_arb SHALL contain only the rr_grant instance, the fixed-select logic, the mode mux, the ptr register and the output register.

Verification
REQ-034 Reset: assert reset with all in_valid=1 -> in_ready=0, and on the next cycle out=0, out_valid=0, out_chan=0.
REQ-035 Fixed mode: mode=0, sel=2, in_valid=4'b1111, channel 2 data 16'hBEEF, out_ready=1 -> out=16'hBEEF and out_chan=2 one cycle later; only in_ready[2] is high.
REQ-036 Round-robin wrap: mode=1, in_valid=4'b1111, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1.
REQ-037 Stall: out_valid=1 with out_ready=0 held 3 cycles -> out stable and in_ready=0; release -> next word appears the following cycle with no lost or duplicated word.
REQ-038 Sparse requests: mode=1, ptr=3, in_valid=4'b0101 -> grant to channel 0, then ptr=1, then next grant to channel 2.
REQ-039 Mid-stall reset: reset pulsed while out_valid=1 and out_ready=0 -> out_valid=0 the next cycle and ptr=0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and index helpers for the mux_arb arbiter and its bench.
package mux_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel index arithmetic with wrap from n-1 back to 0.
  function automatic int wrap_add(int a, int b, int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/mux_arb_rr_grant.sv
// Round-robin search: first requesting channel at or above ptr, wrapping to 0.
module rr_grant
  import mux_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'(wrap_add(int'(ptr), k, N));
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// One-stage registered CHANNELS:1 multiplexer with fixed or round-robin select
// and valid/ready handshakes on both sides.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_chan
);

  logic [SELW-1:0]     ptr_reg;
  logic [WIDTH-1:0]    out_reg;
  logic                out_valid_reg;
  logic [SELW-1:0]     out_chan_reg;

  logic [CHANNELS-1:0] rr_gnt;
  logic [SELW-1:0]     rr_idx;
  logic [CHANNELS-1:0] fix_gnt;
  logic [CHANNELS-1:0] gnt;
  logic [SELW-1:0]     gnt_idx;
  logic                gnt_any;
  logic                open;
  logic [WIDTH-1:0]    word_next;

  rr_grant #(.N(CHANNELS), .W(SELW)) u_rr (
    .req (in_valid),
    .ptr (ptr_reg),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // A select value beyond the last channel matches no decode bit, so no grant.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_fix
      assign fix_gnt[gi] = in_valid[gi] && (sel == SELW'(gi));
    end
  endgenerate

  assign gnt      = (mode == MODE_RR) ? rr_gnt : fix_gnt;
  assign gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
  assign gnt_any  = |gnt;
  assign open     = !out_valid_reg || out_ready;
  assign in_ready = (open && !reset) ? gnt : '0;

  always_comb begin
    word_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt[i]) word_next = word_next | in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_chan_reg  <= '0;
    end else if (open) begin
      if (gnt_any) begin
        out_reg       <= word_next;
        out_chan_reg  <= gnt_idx;
        out_valid_reg <= 1'b1;
        ptr_reg       <= SELW'(wrap_add(int'(gnt_idx), 1, CHANNELS));
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign out_chan  = out_chan_reg;

endmodule

// File: tb/tb_mux_arb.sv
// Randomized and directed bench for mux_arb against a cycle-level reference model.
module tb_mux_arb;
  import mux_arb_pkg::*;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic [W-1:0]  out;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_chan;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [W-1:0] m_out;
  logic         m_valid;
  int           m_chan;
  int           m_ptr;
  bit           m_known = 0;

  always #5 clk = ~clk;

  mux_arb #(.WIDTH(W), .CHANNELS(CH), .SELW(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Channel the spec rules pick this cycle, or -1 for no grant.
  function automatic int grant_of(logic md, logic [SW-1:0] s, logic [CH-1:0] v, int p);
    if (md == MODE_FIXED) begin
      if (int'(s) < CH && v[s]) return int'(s);
      return -1;
    end
    for (int k = 0; k < CH; k++) begin
      if (v[(p + k) % CH]) return (p + k) % CH;
    end
    return -1;
  endfunction

  task automatic step(input logic r, input logic md, input logic [SW-1:0] s,
                      input logic [CH-1:0] v, input logic ordy);
    int g;
    bit opn;
    logic [CH-1:0] exp_rdy;
    reset = r; mode = md; sel = s; in_valid = v; out_ready = ordy;
    @(negedge clk);
    g   = grant_of(md, s, v, m_ptr);
    opn = !m_valid || ordy;
    exp_rdy = (!r && opn && g >= 0) ? CH'(1 << g) : '0;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_known) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out", 32'(out), 32'(m_out));
      check("out_chan", 32'(out_chan), 32'(m_chan));
    end
    @(posedge clk);
    if (r) begin
      m_out = '0; m_valid = 1'b0; m_chan = 0; m_ptr = 0; m_known = 1;
      $display("cyc reset");
    end else if (opn) begin
      if (g >= 0) begin
        m_out = in_data[g*W +: W]; m_chan = g; m_valid = 1'b1; m_ptr = (g + 1) % CH;
        $display("xfer ch=%0d data=%h mode=%0d", g, m_out, md);
      end else begin
        m_valid = 1'b0;
        $display("idle open");
      end
    end else begin
      $display("stall chan=%0d", m_chan);
    end
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = W'($urandom);
  endtask

  initial begin
    logic [W-1:0] held;
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    reset = 1'b0; mode = MODE_FIXED; sel = '0; in_valid = '0; out_ready = 1'b0;
    rand_data();
    @(posedge clk); #1;

    // reset with every channel requesting
    step(1'b1, MODE_RR, 2'd0, 4'b1111, 1'b1);
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_chan", 32'(out_chan), 32'h0);

    // fixed select of channel 2
    rand_data(); in_data[2*W +: W] = 16'hBEEF;
    step(1'b0, MODE_FIXED, 2'd2, 4'b1111, 1'b1);
    check("fix_out", 32'(out), 32'hBEEF);
    check("fix_chan", 32'(out_chan), 32'd2);
    check("fix_valid", 32'(out_valid), 32'd1);

    // round-robin wrap from ptr 0
    step(1'b1, MODE_RR, 2'd0, 4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step(1'b0, MODE_RR, 2'd0, 4'b1111, 1'b1);
      check("rr_chan", 32'(out_chan), 32'(rr_exp[i]));
    end

    // stall three cycles, then release
    held = out;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step(1'b0, MODE_RR, 2'd0, 4'b1111, 1'b0);
      check("stall_out", 32'(out), 32'(held));
    end
    step(1'b0, MODE_RR, 2'd0, 4'b1111, 1'b1);
    check("release_chan", 32'(out_chan), 32'd2);

    // sparse requests starting from ptr 3
    step(1'b1, MODE_RR, 2'd0, 4'b0000, 1'b1);
    step(1'b0, MODE_FIXED, 2'd2, 4'b0100, 1'b1);
    step(1'b0, MODE_RR, 2'd0, 4'b0101, 1'b1);
    check("sparse_first", 32'(out_chan), 32'd0);
    step(1'b0, MODE_RR, 2'd0, 4'b0101, 1'b1);
    check("sparse_second", 32'(out_chan), 32'd2);

    // reset in the middle of a stall
    step(1'b0, MODE_RR, 2'd0, 4'b0101, 1'b0);
    step(1'b1, MODE_RR, 2'd0, 4'b1111, 1'b0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    step(1'b0, MODE_RR, 2'd0, 4'b1111, 1'b0);
    check("midrst_ptr", 32'(out_chan), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      step(($urandom_range(0, 49) == 0), 1'($urandom), SW'($urandom),
           CH'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
